// File: rtl/mem_arbiter_pkg.sv
// mem_arb_p: shared types for the two-port memory arbiter.
// Contents: FSM state encoding (state_t) and the port-owner encoding (owner_t).
// No logic lives here; the arbiter imports these types.
package mem_arb_p;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one word-wide memory port between the core (port 0) and the loader (port 1).
// Latency: request sampled in IDLE at cycle N -> ack at N+MEM_LAT+1; back-to-back period MEM_LAT+2.
// Backpressure: requesters hold req/we/adr/wd until their one-cycle ack; a losing request simply waits in IDLE.
// Ports: clk/reset (sync, active-high); reqX/weX/adrX/wdX in, ackX out per requester;
//        rdata = last read word; mem_adr/mem_wd/mem_we out to memory, mem_rd in (combinational read).
module mem_arbiter
    import mem_arb_p::*;
#(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] adr0,
    input  logic [DW-1:0] wd0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wd1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);

    localparam int                CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_t            last_grant_q, last_grant_d;
    owner_t            owner_q, owner_d;
    logic [AW-1:0]     adr_q, adr_d;
    logic [DW-1:0]     wd_q, wd_d;
    logic              we_q, we_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              mem_we_q, mem_we_d;

    // Under contention the port that did not win last time gets the grant.
    function automatic owner_t rr_pick(input logic r0, input logic r1, input owner_t last);
        if (r0 && r1) begin
            return (last == OWN_CPU) ? OWN_LDR : OWN_CPU;
        end else if (r0) begin
            return OWN_CPU;
        end else begin
            return OWN_LDR;
        end
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        adr_d        = adr_q;
        wd_d         = wd_q;
        we_d         = we_q;
        rdata_d      = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d      = rr_pick(req0, req1, last_grant_q);
                    last_grant_d = owner_d;
                    adr_d        = (owner_d == OWN_CPU) ? adr0 : adr1;
                    wd_d         = (owner_d == OWN_CPU) ? wd0  : wd1;
                    we_d         = (owner_d == OWN_CPU) ? we0  : we1;
                    cnt_d        = CNT_LOAD;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = mem_rd;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered: decode them from the next-state values so the
        // strobe lands in the final BUSY cycle and the ack in the RESP cycle.
        mem_we_d = (state_d == BUSY) && (cnt_d == '0) && we_d;
        ack0_d   = (state_d == RESP) && (owner_d == OWN_CPU);
        ack1_d   = (state_d == RESP) && (owner_d == OWN_LDR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= OWN_LDR;
            owner_q      <= OWN_CPU;
            adr_q        <= '0;
            wd_q         <= '0;
            we_q         <= 1'b0;
            rdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            adr_q        <= adr_d;
            wd_q         <= wd_d;
            we_q         <= we_d;
            rdata_q      <= rdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign rdata   = rdata_q;
    assign mem_adr = adr_q;
    assign mem_wd  = wd_q;
    assign mem_we  = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiter instances (MEM_LAT = 1, 2, 4) driven by a scripted then random
// requester model; expected grants, strobes and acks are queued at issue time and checked by a
// separate monitor against what each instance presents.
module tb_mem_arbiter;

    typedef struct {
        int          port;
        bit          we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          grant;
        int          ack;
    } exp_t;

    typedef struct {
        int          kind;
        int          port;
        bit          we;
        logic [31:0] adr;
        logic [31:0] wd;
        bit          hold;
    } step_t;

    localparam int K_TXN   = 0;
    localparam int K_BAR   = 1;
    localparam int K_ABORT = 2;

    int   checks;
    int   errors;
    int   cyc;
    logic clk = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int i);
        return (i == 16) ? 32'h2010FFFF : (32'hC0DE0000 | 32'(i));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

        logic        reset, req0, we0, req1, we1;
        logic [31:0] adr0, wd0, adr1, wd1;
        logic        ack0, ack1, mem_we;
        logic [31:0] rdata, mem_adr, mem_wd, mem_rd;
        logic [31:0] env_mem [64];
        bit   [63:0] written;
        logic [31:0] ref_mem [64];
        exp_t        exp_q [$];
        step_t       script [$];
        bit          pend [2];
        bit          granted [2];
        bit          hold [2];
        bit          pwe [2];
        logic [31:0] padr [2];
        logic [31:0] pwd [2];
        int          ack_at [2];
        int          free_at;
        int          last;
        logic [31:0] model_rdata;
        bit          started;
        bit          done;

        mem_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) u_dut (
            .clk(clk), .reset(reset),
            .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0), .ack0(ack0),
            .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1), .ack1(ack1),
            .rdata(rdata), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
        );

        // Memory behind the arbiter: combinational read, write on the strobe edge.
        assign mem_rd = written[mem_adr[7:2]] ? env_mem[mem_adr[7:2]] : init_val(int'(mem_adr[7:2]));
        always @(posedge clk) begin
            if (mem_we) begin
                env_mem[mem_adr[7:2]] <= mem_wd;
                written[mem_adr[7:2]] <= 1'b1;
            end
        end

        task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
            check($sformatf("L%0d_%s", LAT, name), act, exp);
        endtask

        task automatic add(input int kind, input int port, input bit we, input logic [31:0] adr,
                           input logic [31:0] wd, input bit h);
            step_t s;
            s.kind = kind; s.port = port; s.we = we; s.adr = adr; s.wd = wd; s.hold = h;
            script.push_back(s);
        endtask

        task automatic load(input int p, input bit we, input logic [31:0] adr, input logic [31:0] wd,
                            input bit h);
            pend[p] = 1'b1; granted[p] = 1'b0; pwe[p] = we; padr[p] = adr; pwd[p] = wd; hold[p] = h;
        endtask

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic drive_ports();
            logic        r [2];
            logic        w [2];
            logic [31:0] a [2];
            logic [31:0] d [2];
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && (!granted[p] || hold[p])) begin
                    r[p] = 1'b1; w[p] = pwe[p]; a[p] = padr[p]; d[p] = pwd[p];
                end else begin
                    // Not requesting (or dropped after grant): scramble the fields.
                    r[p] = 1'b0; w[p] = 1'($urandom); a[p] = $urandom; d[p] = $urandom;
                end
            end
            req0 = r[0]; we0 = w[0]; adr0 = a[0]; wd0 = d[0];
            req1 = r[1]; we1 = w[1]; adr1 = a[1]; wd1 = d[1];
        endtask

        // Reference: when the port is free and someone asks, grant by alternation,
        // ack LAT+1 cycles later, port free again one cycle after the ack.
        task automatic arbitrate(input int t);
            exp_t e;
            int   p;
            if (t < free_at || !(req0 || req1)) return;
            if (req0 && req1) p = (last == 0) ? 1 : 0;
            else              p = req0 ? 0 : 1;
            granted[p] = 1'b1;
            ack_at[p]  = t + LAT + 1;
            free_at    = t + LAT + 2;
            last       = p;
            if (pwe[p]) ref_mem[padr[p][7:2]] = pwd[p];
            else        model_rdata = ref_mem[padr[p][7:2]];
            e.port = p; e.we = pwe[p]; e.adr = padr[p]; e.wd = pwd[p]; e.rd = model_rdata;
            e.grant = t; e.ack = t + LAT + 1;
            exp_q.push_back(e);
        endtask

        // Core write granted, then reset during its first BUSY cycle.
        task automatic abort_write(input logic [31:0] adr, input logic [31:0] wd);
            pend[0] = 1'b0; pend[1] = 1'b0; granted[0] = 1'b0; granted[1] = 1'b0;
            req0 = 1'b1; we0 = 1'b1; adr0 = adr; wd0 = wd; req1 = 1'b0; we1 = 1'b0;
            // With one-cycle latency the strobe is already up in the reset cycle.
            if (LAT == 1) ref_mem[adr[7:2]] = wd;
            tick();
            req0 = 1'b0;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("abort_rdata", rdata, 0);
            chk("abort_ack", {ack1, ack0}, 0);
            chk("abort_we", mem_we, 0);
            last = 1; free_at = cyc; model_rdata = '0;
        endtask

        task automatic cycle_step(input bit allow_rand);
            int    t;
            int    idx;
            step_t s;
            t = cyc;
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && granted[p] && t > ack_at[p]) pend[p] = 1'b0;
            end
            while (script.size() != 0) begin
                s = script[0];
                if (s.kind == K_BAR) begin
                    if (!pend[0] && !pend[1] && t >= free_at) void'(script.pop_front());
                    else break;
                end else if (s.kind == K_TXN) begin
                    if (!pend[s.port]) begin
                        load(s.port, s.we, s.adr, s.wd, s.hold);
                        void'(script.pop_front());
                    end else break;
                end else begin
                    if (!pend[0] && !pend[1] && t >= free_at) begin
                        void'(script.pop_front());
                        abort_write(s.adr, s.wd);
                        t = cyc;
                    end else break;
                end
            end
            if (allow_rand && script.size() == 0) begin
                for (int p = 0; p < 2; p++) begin
                    if (!pend[p] && $urandom_range(0, 1) == 1) begin
                        idx = $urandom_range(0, 63);
                        load(p, 1'($urandom), ($urandom & 32'hFFFFFF00) | 32'(idx << 2), $urandom,
                             $urandom_range(0, 3) != 0);
                    end
                end
            end
            drive_ports();
            arbitrate(t);
            tick();
        endtask

        initial begin
            reset = 1'b1;
            req0 = 1'b0; we0 = 1'b0; adr0 = '0; wd0 = '0;
            req1 = 1'b0; we1 = 1'b0; adr1 = '0; wd1 = '0;
            for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
            model_rdata = '0;
            last = 1;
            // Contention from reset: expected order 0,1,0,1.
            add(K_TXN, 0, 1'b0, 32'h40,  32'h0,        1'b1);
            add(K_TXN, 1, 1'b1, 32'h100, 32'hA1,       1'b1);
            add(K_TXN, 0, 1'b1, 32'h104, 32'hA2,       1'b1);
            add(K_TXN, 1, 1'b0, 32'h100, 32'h0,        1'b1);
            add(K_BAR, 0, 1'b0, 32'h0,   32'h0,        1'b0);
            add(K_TXN, 0, 1'b0, 32'h40,  32'h0,        1'b1);
            add(K_BAR, 0, 1'b0, 32'h0,   32'h0,        1'b0);
            add(K_TXN, 1, 1'b1, 32'h54,  32'hDEADBEEF, 1'b1);
            add(K_BAR, 0, 1'b0, 32'h0,   32'h0,        1'b0);
            add(K_TXN, 0, 1'b1, 32'h8,   32'h11,       1'b0);
            add(K_BAR, 0, 1'b0, 32'h0,   32'h0,        1'b0);
            add(K_TXN, 0, 1'b0, 32'h8,   32'h0,        1'b1);
            add(K_BAR, 0, 1'b0, 32'h0,   32'h0,        1'b0);
            add(K_ABORT, 0, 1'b1, 32'hC, 32'h77,       1'b0);
            add(K_TXN, 0, 1'b0, 32'hC,   32'h0,        1'b1);
            add(K_TXN, 1, 1'b0, 32'h40,  32'h0,        1'b1);
            add(K_BAR, 0, 1'b0, 32'h0,   32'h0,        1'b0);

            repeat (3) @(posedge clk);
            #1;
            chk("rst_ack", {ack1, ack0}, 0);
            chk("rst_we", mem_we, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_adr", mem_adr, 0);
            chk("rst_wd", mem_wd, 0);
            reset   = 1'b0;
            free_at = cyc;
            started = 1'b1;

            for (int k = 0; k < 2000 && script.size() != 0; k++) cycle_step(1'b0);
            for (int n = 0; n < 400; n++) cycle_step(1'b1);
            for (int k = 0; k < 100; k++) begin
                if (!pend[0] && !pend[1] && exp_q.size() == 0) break;
                cycle_step(1'b0);
            end
            chk("drain_outstanding", exp_q.size(), 0);
            tick();
            done = 1'b1;
        end

        always @(negedge clk) begin
            exp_t e;
            if (started && !reset) begin
                if (exp_q.size() != 0 && cyc > exp_q[0].ack) begin
                    chk("ack_missing_at", cyc, exp_q[0].ack);
                    void'(exp_q.pop_front());
                end
                if (exp_q.size() != 0 && cyc > exp_q[0].grant && cyc < exp_q[0].ack) begin
                    e = exp_q[0];
                    chk("busy_adr", mem_adr, e.adr);
                    chk("busy_wd", mem_wd, e.wd);
                    chk("busy_we", mem_we, (e.we && cyc == e.ack - 1));
                end else if (mem_we) begin
                    chk("stray_we", mem_we, 0);
                end
                if (ack0 || ack1) begin
                    chk("ack_onehot", ack0 & ack1, 0);
                    if (exp_q.size() == 0) begin
                        chk("stray_ack", {ack1, ack0}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_port", {ack1, ack0}, (e.port == 0) ? 2'b01 : 2'b10);
                        chk("ack_cycle", cyc, e.ack);
                        chk("rdata", rdata, e.rd);
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 50000; k++) begin
            if (g_lat[0].done && g_lat[1].done && g_lat[2].done) break;
            @(posedge clk);
        end
        if (!(g_lat[0].done && g_lat[1].done && g_lat[2].done)) begin
            checks++;
            errors++;
            $display("FAIL run_timeout actual=not_done required=done");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single word-wide memory port between two requesters: the multicycle MIPS core (port 0) and a program loader/DMA engine (port 1).
- Sits between the requesters and the unified instruction/data memory.
- Serialises accesses with round-robin fairness and a configurable memory latency.
- Returns read data and a one-cycle acknowledge to the granted requester.

Parameters:
- MEM_LAT, 1, cycles the memory address/data are held before read capture / write strobe; must be >= 1
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req0  input  1  core access request; held until ack0
- we0  input  1  core write enable (1 = write)
- adr0  input  AW  core byte address
- wd0  input  DW  core write data
- ack0  output  1  one-cycle completion pulse to core
- req1  input  1  loader request; held until ack1
- we1  input  1  loader write enable
- adr1  input  AW  loader byte address
- wd1  input  DW  loader write data
- ack1  output  1  one-cycle completion pulse to loader
- rdata  output  DW  read data of last completed read; valid in the ack cycle
- mem_adr  output  AW  memory address
- mem_wd  output  DW  memory write data
- mem_we  output  1  memory write strobe
- mem_rd  input  DW  memory read data (combinational read)

Behaviour:
- Reset:
  - state = IDLE, cnt = 0, last_grant = 1 (so port 0 wins the first tie).
  - Latched adr/wd/we/owner = 0; rdata = 0.
  - ack0 = ack1 = mem_we = 0.
- States:
  - IDLE -> BUSY when req0 | req1. Arbitration happens in the same cycle.
    - Latch owner, address, write data and we.
    - Set cnt = MEM_LAT-1.
    - Update last_grant = owner.
  - BUSY: mem_adr and mem_wd are driven from the latches.
    - cnt decrements each cycle.
    - When cnt == 0: mem_we = latched we for exactly this cycle; rdata <= mem_rd if read (write leaves rdata unchanged); -> RESP.
  - RESP: ack[owner] = 1 for one cycle, then -> IDLE.
- Arbitration:
  - Only one request: grant it.
  - Both requests: grant the port != last_grant (strict alternation under contention).
- Latency: request sampled in IDLE at cycle N -> ack at cycle N+MEM_LAT+1. Minimum back-to-back period is MEM_LAT+2 cycles.
- Handshake:
  - Requester holds req/we/adr/wd stable until it sees ack.
  - A req still high in the cycle after ack (IDLE) is treated as a new request.
  - req dropped before ack: the transaction still completes and ack still pulses.
  - Inputs changing after latch have no effect.
- Output timing:
  - mem_we is never asserted outside the final BUSY cycle.
  - Address/data are stable for all MEM_LAT BUSY cycles.
  - mem_adr/mem_wd are driven from the latches in all states.
  - ack0 and ack1 are never simultaneously 1.
- Reset mid-operation: next edge returns to IDLE with no ack. A write strobe already high in the reset cycle is not suppressed (synchronous semantics); no later strobe occurs.
- Widths: no arithmetic on addresses/data. cnt is $clog2(MEM_LAT+1) bits wide and never wraps (loaded, then decremented to 0).

Decomposition:
- Package mem_arb_p holds:
  - state_t enum {IDLE, BUSY, RESP}
  - owner_t enum {OWN_CPU=0, OWN_LDR=1}
- Single module; the round-robin pick is a small combinational function inside it. No sub-module needed.

Test Plan (MEM_LAT=2 unless stated):
- Single read: req0=1, we0=0, adr0=0x40, mem holds 0x2010FFFF at 0x40 -> mem_adr=0x40 for 2 cycles, mem_we never 1, ack0 at N+3, rdata=0x2010FFFF, ack1 stays 0.
- Single write: req1=1, we1=1, adr1=0x54, wd1=0xDEADBEEF -> mem_we high exactly one cycle (N+2) with mem_adr=0x54, mem_wd=0xDEADBEEF; ack1 at N+3; rdata unchanged.
- Contention: req0 and req1 held high continuously for 4 transactions from reset -> grant order 0,1,0,1; acks 4 cycles apart.
- Request dropped early: req0 pulsed one cycle with write 0x11 to 0x8 -> write still occurs, ack0 still pulses once.
- Reset mid-BUSY: reset asserted in first BUSY cycle of a write -> no mem_we pulse, no ack; next request is granted to port 0 with normal latency.
- MEM_LAT=1: read 0x0 -> ack at N+2, mem_we never high; MEM_LAT=4 -> ack at N+5.
